sdr_rd_capture: RTL and testbench

//  Read-side neighbour of the SDRAM write data path. Samples the SDRAM DQ bus CAS_LAT

---
 rtl/sdr_rd_capture.sv | 137 +++++++++++++
 tb/tb_sdr_rd_capture.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sdr_rd_capture.sv
// SDRAM read-data capture: samples DQ CAS_LAT cycles after each READ, buffers BURST_LEN
// words per burst in a FWFT FIFO and hands them to the host with valid/ready and a last tag.
module sdr_rd_capture #(
  parameter int unsigned DSIZE      = 32,
  parameter int unsigned CAS_LAT    = 2,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             RD_CMD,
  input  logic [DSIZE-1:0] DQIN,
  output logic [DSIZE-1:0] RD_DATA,
  output logic             RD_LAST,
  output logic             RD_VALID,
  input  logic             RD_READY,
  output logic             BUSY,
  output logic             OVERFLOW,
  output logic             CMD_ERR
);

  localparam int unsigned SR_W  = CAS_LAT + BURST_LEN;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned GAP_W = $clog2(BURST_LEN + 1);

  // Bit 0 of the token register is the capture strobe; a READ loads one token per word
  // so that word k reaches bit 0 just before edge t+CAS_LAT+k.
  localparam logic [SR_W-1:0] TOKEN_MASK =
    ((SR_W'(1) << BURST_LEN) - SR_W'(1)) << (CAS_LAT - 1);
  localparam logic [SR_W-1:0] LAST_MASK = SR_W'(1) << (CAS_LAT + BURST_LEN - 2);

  logic [SR_W-1:0]  token_sr;
  logic [SR_W-1:0]  last_sr;
  logic [GAP_W-1:0] gap_cnt;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic [DSIZE-1:0] mem_data [0:FIFO_DEPTH-1];
  logic             mem_last [0:FIFO_DEPTH-1];

  logic             cmd_acc;
  logic             cmd_rej;
  logic             cap;
  logic             cap_last;
  logic             pop;
  logic             push;
  logic             drop;
  logic [PTR_W-1:0] wr_ptr_n;
  logic [PTR_W-1:0] rd_ptr_n;
  logic [CNT_W-1:0] count_n;
  logic [GAP_W-1:0] gap_cnt_n;
  logic             head_valid_n;
  logic [DSIZE-1:0] head_data_n;
  logic             head_last_n;

  // Command spacing, FIFO occupancy and next head-of-queue selection
  always_comb begin
    cmd_acc      = RD_CMD & (gap_cnt >= GAP_W'(BURST_LEN));
    cmd_rej      = RD_CMD & ~cmd_acc;
    cap          = token_sr[0];
    cap_last     = last_sr[0];
    pop          = RD_VALID & RD_READY;
    push         = cap & ((count < CNT_W'(FIFO_DEPTH)) | pop);
    drop         = cap & ~push;
    wr_ptr_n     = wr_ptr + PTR_W'(push);
    rd_ptr_n     = rd_ptr + PTR_W'(pop);
    count_n      = count;
    gap_cnt_n    = gap_cnt;
    head_data_n  = RD_DATA;
    head_last_n  = 1'b0;

    case ({push, pop})
      2'b10:   count_n = count + CNT_W'(1);
      2'b01:   count_n = count - CNT_W'(1);
      default: count_n = count;
    endcase

    if (cmd_acc) begin
      gap_cnt_n = GAP_W'(1);
    end else if (gap_cnt < GAP_W'(BURST_LEN)) begin
      gap_cnt_n = gap_cnt + GAP_W'(1);
    end

    head_valid_n = (count_n != '0);
    // A word written this edge into the new head slot bypasses the memory
    if (head_valid_n) begin
      if (push && (wr_ptr == rd_ptr_n)) begin
        head_data_n = DQIN;
        head_last_n = cap_last;
      end else begin
        head_data_n = mem_data[rd_ptr_n];
        head_last_n = mem_last[rd_ptr_n];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      token_sr <= '0;
      last_sr  <= '0;
      gap_cnt  <= GAP_W'(BURST_LEN);
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      RD_DATA  <= '0;
      RD_LAST  <= 1'b0;
      RD_VALID <= 1'b0;
      OVERFLOW <= 1'b0;
      CMD_ERR  <= 1'b0;
    end else begin
      token_sr <= (token_sr >> 1) | (cmd_acc ? TOKEN_MASK : '0);
      last_sr  <= (last_sr >> 1) | (cmd_acc ? LAST_MASK : '0);
      gap_cnt  <= gap_cnt_n;
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      count    <= count_n;
      RD_DATA  <= head_data_n;
      RD_LAST  <= head_last_n;
      RD_VALID <= head_valid_n;
      OVERFLOW <= OVERFLOW | drop;
      CMD_ERR  <= CMD_ERR | cmd_rej;
    end
  end

  // Storage carries no reset; pointers and count define what is live
  always_ff @(posedge CLK) begin
    if (!RESET && push) begin
      mem_data[wr_ptr] <= DQIN;
      mem_last[wr_ptr] <= cap_last;
    end
  end

  assign BUSY = (|token_sr) | RD_VALID;

endmodule

// File: tb/tb_sdr_rd_capture.sv
// Directed bench for sdr_rd_capture: DQIN carries the edge index so every captured word
// identifies the edge that sampled it.
module tb_sdr_rd_capture;

  localparam int unsigned DSIZE = 32;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             RD_CMD;
  logic [DSIZE-1:0] DQIN;
  logic [DSIZE-1:0] RD_DATA;
  logic             RD_LAST;
  logic             RD_VALID;
  logic             RD_READY;
  logic             BUSY;
  logic             OVERFLOW;
  logic             CMD_ERR;

  int errors = 0;
  int checks = 0;
  int ecnt   = 0;
  int t0     = 0;

  sdr_rd_capture #(
    .DSIZE(DSIZE), .CAS_LAT(2), .BURST_LEN(4), .FIFO_DEPTH(8)
  ) dut (
    .CLK(CLK), .RESET(RESET), .RD_CMD(RD_CMD), .DQIN(DQIN),
    .RD_DATA(RD_DATA), .RD_LAST(RD_LAST), .RD_VALID(RD_VALID), .RD_READY(RD_READY),
    .BUSY(BUSY), .OVERFLOW(OVERFLOW), .CMD_ERR(CMD_ERR)
  );

  always #5 CLK = ~CLK;

  // Advance one edge; DQIN is set to the number of the edge that will sample it
  task automatic tick();
    @(posedge CLK);
    #1;
    ecnt++;
    DQIN = DSIZE'(ecnt + 1);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    RESET    = 1'b1;
    RD_CMD   = 1'b1;
    RD_READY = 1'b1;
    DQIN     = DSIZE'(1);

    // Reset state, with RD_CMD held high during reset
    repeat (3) tick();
    chk("rst_valid", 64'(RD_VALID), 64'(0));
    chk("rst_last", 64'(RD_LAST), 64'(0));
    chk("rst_data", 64'(RD_DATA), 64'(0));
    chk("rst_busy", 64'(BUSY), 64'(0));
    chk("rst_ovf", 64'(OVERFLOW), 64'(0));
    chk("rst_cmderr", 64'(CMD_ERR), 64'(0));
    RESET  = 1'b0;
    RD_CMD = 1'b0;
    tick();
    chk("post_rst_busy", 64'(BUSY), 64'(0));
    chk("post_rst_valid", 64'(RD_VALID), 64'(0));

    // 1: single burst, words t0+2..t0+5, last on t0+5
    RD_CMD = 1'b1;
    tick();
    t0 = ecnt;
    RD_CMD = 1'b0;
    tick();
    chk("t1_wait_valid", 64'(RD_VALID), 64'(0));
    chk("t1_wait_busy", 64'(BUSY), 64'(1));
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t1_valid", 64'(RD_VALID), 64'(1));
      chk("t1_data", 64'(RD_DATA), 64'(t0 + 2 + k));
      chk("t1_last", 64'(RD_LAST), 64'(k == 3));
    end
    tick();
    chk("t1_end_valid", 64'(RD_VALID), 64'(0));
    chk("t1_end_last", 64'(RD_LAST), 64'(0));
    chk("t1_end_hold", 64'(RD_DATA), 64'(t0 + 5));
    chk("t1_end_busy", 64'(BUSY), 64'(0));

    // 2: commands 4 cycles apart give 8 gapless captures
    RD_CMD = 1'b1;
    tick();
    t0 = ecnt;
    for (int i = 1; i <= 11; i++) begin
      RD_CMD = (i == 4);
      tick();
      RD_CMD = 1'b0;
      if (i >= 2 && i <= 9) begin
        chk("t2_valid", 64'(RD_VALID), 64'(1));
        chk("t2_data", 64'(RD_DATA), 64'(t0 + i));
        chk("t2_last", 64'(RD_LAST), 64'(i == 5 || i == 9));
      end else begin
        chk("t2_idle_valid", 64'(RD_VALID), 64'(0));
      end
    end
    chk("t2_cmderr", 64'(CMD_ERR), 64'(0));

    // 3: second command 2 cycles later is rejected
    RD_CMD = 1'b1;
    tick();
    t0 = ecnt;
    for (int i = 1; i <= 8; i++) begin
      RD_CMD = (i == 2);
      tick();
      RD_CMD = 1'b0;
      chk("t3_cmderr", 64'(CMD_ERR), 64'(i >= 2));
      chk("t3_valid", 64'(RD_VALID), 64'(i >= 2 && i <= 5));
      if (i >= 2 && i <= 5) begin
        chk("t3_data", 64'(RD_DATA), 64'(t0 + i));
      end
    end
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("t3_cmderr_clr", 64'(CMD_ERR), 64'(0));

    // 4: three bursts with host stalled; last 4 words dropped
    RD_READY = 1'b0;
    RD_CMD   = 1'b1;
    tick();
    t0 = ecnt;
    for (int i = 1; i <= 14; i++) begin
      RD_CMD = (i == 4 || i == 8);
      tick();
      RD_CMD = 1'b0;
      chk("t4_valid", 64'(RD_VALID), 64'(i >= 2));
      chk("t4_ovf", 64'(OVERFLOW), 64'(i >= 10));
      if (i >= 2) begin
        chk("t4_hold_data", 64'(RD_DATA), 64'(t0 + 2));
        chk("t4_hold_last", 64'(RD_LAST), 64'(0));
      end
    end
    RD_READY = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      chk("t4_drain_valid", 64'(RD_VALID), 64'(1));
      chk("t4_drain_data", 64'(RD_DATA), 64'(t0 + 1 + j));
      chk("t4_drain_last", 64'(RD_LAST), 64'(j == 4 || j == 8));
      tick();
    end
    chk("t4_empty", 64'(RD_VALID), 64'(0));
    chk("t4_ovf_sticky", 64'(OVERFLOW), 64'(1));

    // 5: full FIFO with pops coinciding with captures never overflows
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("t5_ovf_clr", 64'(OVERFLOW), 64'(0));
    RD_READY = 1'b0;
    RD_CMD   = 1'b1;
    tick();
    t0 = ecnt;
    for (int i = 1; i <= 13; i++) begin
      RD_CMD   = (i == 4 || i == 8);
      RD_READY = (i >= 10);
      tick();
      RD_CMD = 1'b0;
      chk("t5_ovf", 64'(OVERFLOW), 64'(0));
      if (i == 9) begin
        chk("t5_full_head", 64'(RD_DATA), 64'(t0 + 2));
      end
    end
    chk("t5_head", 64'(RD_DATA), 64'(t0 + 6));
    for (int j = 0; j < 8; j++) begin
      chk("t5_drain_valid", 64'(RD_VALID), 64'(1));
      chk("t5_drain_data", 64'(RD_DATA), 64'(t0 + 6 + j));
      chk("t5_drain_last", 64'(RD_LAST), 64'(j == 3 || j == 7));
      tick();
    end
    chk("t5_empty", 64'(RD_VALID), 64'(0));
    chk("t5_ovf_end", 64'(OVERFLOW), 64'(0));

    // 6: reset one cycle after the first capture aborts the burst
    RD_CMD = 1'b1;
    tick();
    t0 = ecnt;
    RD_CMD = 1'b0;
    tick();
    tick();
    chk("t6_first_valid", 64'(RD_VALID), 64'(1));
    chk("t6_first_data", 64'(RD_DATA), 64'(t0 + 2));
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("t6_rst_valid", 64'(RD_VALID), 64'(0));
    chk("t6_rst_busy", 64'(BUSY), 64'(0));
    chk("t6_rst_data", 64'(RD_DATA), 64'(0));
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t6_quiet_valid", 64'(RD_VALID), 64'(0));
    end
    chk("t6_quiet_busy", 64'(BUSY), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
